// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared state type, default width and counter sizing for the serial word feeder
package serial_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/feeder_hold_buf.sv
// feeder_hold_buf: one-entry word buffer that keeps the serial stream gapless between frames
module feeder_hold_buf
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full  <= 1'b0;
      rdata <= '0;
    end else begin
      full <= wr_en || (full && !rd_en);
      if (wr_en) rdata <= wdata;
    end
endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: parallel-to-serial front end feeding one bit per clock to a pattern detector
// SERIAL_FEEDER_PARITY_EN appends one even-parity bit to every frame
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n, sh_src, rdata;
  logic buf_full, xfer, last, free, load, wr_en, rd_en, dout_n, frame_done_n;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic par;
`endif
  assign load_ready = rst && !buf_full;
  feeder_hold_buf #(.WIDTH(WIDTH)) u_buf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(data_in), .rdata(rdata), .full(buf_full)
  );
  // sh always holds the not-yet-driven bits with the next one at its head
  always_comb begin
    xfer = load_valid && load_ready;
`ifdef SERIAL_FEEDER_PARITY_EN
    last = state == PARITY;
`else
    last = state == SHIFT && cnt == LAST;
`endif
    free   = state == IDLE || last;
    rd_en  = free && buf_full;
    wr_en  = xfer && !free;
    load   = free && (buf_full || xfer);
    sh_src = load ? (buf_full ? rdata : data_in) : sh;
    sh_n   = MSB_FIRST ? {sh_src[WIDTH-2:0], 1'b0} : {1'b0, sh_src[WIDTH-1:1]};
    state_n = load ? SHIFT : last ? IDLE : state;
`ifdef SERIAL_FEEDER_PARITY_EN
    if (!load && state == SHIFT && cnt == LAST) state_n = PARITY;
`endif
    cnt_n  = (state_n == SHIFT && !load) ? cnt + CW'(1) : '0;
    dout_n = (state_n == SHIFT) && (MSB_FIRST ? sh_src[WIDTH-1] : sh_src[0]);
`ifdef SERIAL_FEEDER_PARITY_EN
    if (state_n == PARITY) dout_n = par;
    frame_done_n = state_n == PARITY;
`else
    frame_done_n = state_n == SHIFT && cnt_n == LAST;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      dout       <= dout_n;
      dout_valid <= state_n != IDLE;
      frame_done <= frame_done_n;
    end
`ifdef SERIAL_FEEDER_PARITY_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) par <= 1'b0;
    else if (load) par <= ^sh_src;
`endif
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of framing, back-to-back flow, buffering, bit order and reset
module tb_serial_word_feeder;
  localparam int W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + int'(PAR);
  logic clk = 1'b0, rst = 1'b0, load_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic m_ready, m_dout, m_valid, m_done, l_ready, l_dout, l_valid, l_done;
  int checks = 0, errors = 0, fd_total = 0, dv_total = 0;
  logic exp_bit[$], exp_done[$];

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid), .load_ready(m_ready),
    .dout(m_dout), .dout_valid(m_valid), .frame_done(m_done)
  );
  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid), .load_ready(l_ready),
    .dout(l_dout), .dout_valid(l_valid), .frame_done(l_done)
  );

  always @(posedge clk) begin
    fd_total <= fd_total + int'(m_done);
    dv_total <= dv_total + int'(m_valid);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input logic p);
    for (int i = 7; i >= 0; i--) begin
      exp_bit.push_back(b[i]);
      exp_done.push_back(i == 0 && !PAR);
    end
    if (PAR) begin
      exp_bit.push_back(p);
      exp_done.push_back(1'b1);
    end
  endtask

  task automatic run_stream(input string tag, input bit lsb);
    int n = exp_bit.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_dout"}, lsb ? l_dout : m_dout, exp_bit[i]);
      check({tag, "_valid"}, lsb ? l_valid : m_valid, 1);
      check({tag, "_done"}, lsb ? l_done : m_done, exp_done[i]);
    end
  endtask

  task automatic pulse(input logic [7:0] w);
    data_in = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, fd0, dv0;
    @(negedge clk);
    check("rst_dout", m_dout, 0);
    check("rst_valid", m_valid, 0);
    check("rst_done", m_done, 0);
    check("rst_ready", m_ready, 0);
    check("rst_ready_lsb", l_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", m_ready, 1);
    check("idle_valid", m_valid, 0);
    // single frame B0
    exp_bit.delete(); exp_done.delete();
    add_frame(8'b1011_0000, 1'b1);
    fork
      run_stream("b0", 1'b0);
      pulse(8'hB0);
    join
    @(negedge clk);
    check("b0_idle_dout", m_dout, 0);
    check("b0_idle_valid", m_valid, 0);
    // back-to-back 05 then B6
    exp_bit.delete(); exp_done.delete();
    add_frame(8'b0000_0101, 1'b0);
    add_frame(8'b1011_0110, 1'b1);
    data_in = 8'h05;
    load_valid = 1'b1;
    fork
      run_stream("b2b", 1'b0);
      begin
        @(negedge clk);
        data_in = 8'hB6;
        @(negedge clk);
        load_valid = 1'b0;
      end
    join
    @(negedge clk);
    check("b2b_idle_valid", m_valid, 0);
    // three words offered on consecutive cycles
    fd0 = fd_total;
    dv0 = dv_total;
    data_in = 8'h11;
    load_valid = 1'b1;
    @(negedge clk);
    check("w2_ready", m_ready, 1);
    data_in = 8'h22;
    @(negedge clk);
    check("w3_blocked", m_ready, 0);
    data_in = 8'h33;
    k = 0;
    while (!m_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("w3_wait", k, FL - 1);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3 * FL + 4) @(negedge clk);
    check("w3_frames", fd_total - fd0, 3);
    check("w3_bits", dv_total - dv0, 3 * FL);
    // LSB-first 0D
    exp_bit.delete(); exp_done.delete();
    add_frame(8'b1011_0000, 1'b1);
    fork
      run_stream("lsb", 1'b1);
      pulse(8'h0D);
    join
    @(negedge clk);
    check("lsb_idle_valid", l_valid, 0);
    // reset during bit 4 of FF with AA buffered
    fd0 = fd_total;
    data_in = 8'hFF;
    load_valid = 1'b1;
    @(negedge clk);
    data_in = 8'hAA;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_valid", m_valid, 1);
    check("mid_dout", m_dout, 1);
    check("mid_ready", m_ready, 0);
    rst = 1'b0;
    #1;
    check("arst_dout", m_dout, 0);
    check("arst_valid", m_valid, 0);
    check("arst_done", m_done, 0);
    check("arst_ready", m_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_ready", m_ready, 1);
    check("post_valid", m_valid, 0);
    repeat (FL + 2) @(negedge clk);
    check("post_idle", m_valid, 0);
    check("post_no_done", fd_total - fd0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
